// File: rtl/debounce_pkg.sv
// Shared defaults and width helpers for the push-button debounce bank.
package debounce_pkg;

    localparam int unsigned DEF_N_CH         = 4;
    localparam int unsigned DEF_STABLE_CNT   = 3;
    localparam int unsigned DEF_REPEAT_DELAY = 8;
    localparam int unsigned DEF_REPEAT_RATE  = 4;

    // Ceiling log2; clog2(1) = 0, so callers pass (max value + 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < value) w++;
        return w;
    endfunction

    function automatic int unsigned maxu(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Button bus between board pins / control FSM and the debounce bank.
interface debounce_bank_if
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH
);
    logic            sample_en;
    logic [N_CH-1:0] btn_raw;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic [N_CH-1:0] btn_press;

    modport master (
        output sample_en, btn_raw, repeat_en,
        input  btn_level, btn_rise, btn_fall, btn_press
    );

    modport slave (
        input  sample_en, btn_raw, repeat_en,
        output btn_level, btn_rise, btn_fall, btn_press
    );
endinterface

// File: rtl/debounce_chan.sv
// One button channel: 2-flop synchroniser, stability filter, edge pulses, auto-repeat.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT   = DEF_STABLE_CNT,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clkDis,
    input  logic rst,
    input  logic sampleEn,
    input  logic btnRaw,
    input  logic repeatEn,
    output logic btnLevel,
    output logic btnRise,
    output logic btnFall,
    output logic btnPress
);
    localparam int unsigned CW = clog2(STABLE_CNT + 1);
    localparam int unsigned HW = clog2(maxu(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] DELAY_T  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] RATE_T   = HW'(REPEAT_RATE);

    logic          syncA, syncB;
    logic [CW-1:0] stab;
    logic [HW-1:0] hold;
    logic          repeated;
    logic          flip, holdActive, repeatHit;
    logic [HW-1:0] holdNext;

    // A level flip this edge also suppresses the hold logic, so a release never repeats.
    always_comb begin
        flip       = sampleEn && (syncB != btnLevel) && (stab == CNT_LAST);
        holdActive = btnLevel && repeatEn && !flip;
        holdNext   = hold + HW'(1);
        repeatHit  = holdActive && sampleEn && (holdNext == (repeated ? RATE_T : DELAY_T));
    end

    always_ff @(posedge clkDis) begin
        if (rst) begin
            syncA    <= 1'b0;
            syncB    <= 1'b0;
            stab     <= '0;
            btnLevel <= 1'b0;
            btnRise  <= 1'b0;
            btnFall  <= 1'b0;
            btnPress <= 1'b0;
            hold     <= '0;
            repeated <= 1'b0;
        end else begin
            syncA <= btnRaw;
            syncB <= syncA;

            if (sampleEn) begin
                if (syncB == btnLevel) begin
                    stab <= '0;
                end else if (stab == CNT_LAST) begin
                    btnLevel <= ~btnLevel;
                    stab     <= '0;
                end else begin
                    stab <= stab + CW'(1);
                end
            end

            btnRise  <= flip && !btnLevel;
            btnFall  <= flip && btnLevel;
            btnPress <= (flip && !btnLevel) || repeatHit;

            if (!holdActive) begin
                hold     <= '0;
                repeated <= 1'b0;
            end else if (sampleEn) begin
                if (repeatHit) begin
                    hold     <= '0;
                    repeated <= 1'b1;
                end else begin
                    hold <= holdNext;
                end
            end
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounced buttons on clkDis; bus width must match N_CH.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH         = DEF_N_CH,
    parameter int unsigned STABLE_CNT   = DEF_STABLE_CNT,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input logic             clkDis,
    input logic             rst,
    debounce_bank_if.slave  bus
);

    for (genvar i = 0; i < N_CH; i++) begin : gChan
        debounce_chan #(
            .STABLE_CNT   (STABLE_CNT),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) uChan (
            .clkDis   (clkDis),
            .rst      (rst),
            .sampleEn (bus.sample_en),
            .btnRaw   (bus.btn_raw[i]),
            .repeatEn (bus.repeat_en[i]),
            .btnLevel (bus.btn_level[i]),
            .btnRise  (bus.btn_rise[i]),
            .btnFall  (bus.btn_fall[i]),
            .btnPress (bus.btn_press[i])
        );
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised, multi-channel successor to the two-button debouncer in the stopwatch front end.
- Synchronises N_CH raw push-button inputs and filters each one with a counter that requires STABLE_CNT consecutive agreeing samples.
- Outputs per channel: clean level, one-cycle press and release pulses, and an optional hold-to-auto-repeat press pulse. Used for reset, pause, select and adjust buttons.
- Sits between board pins and the stopwatch control FSM; all logic runs on clkDis.

Parameters:
- N_CH, 4, number of independent button channels.
- STABLE_CNT, 3, consecutive sample_en ticks of disagreement required to flip a channel's level; legal range 1..255.
- REPEAT_DELAY, 8, sample_en ticks from a debounced press to the first auto-repeat pulse; must be ≥1.
- REPEAT_RATE, 4, sample_en ticks between subsequent auto-repeat pulses; must be ≥1.

Ports:
- clkDis, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- sample_en, in, 1, one-cycle sampling strobe; tying it to 1 is legal.
- btn_raw, in, N_CH, asynchronous raw button inputs, active-high.
- repeat_en, in, N_CH, per-channel auto-repeat enable.
- btn_level, out, N_CH, debounced level.
- btn_rise, out, N_CH, one-cycle pulse on debounced 0→1.
- btn_fall, out, N_CH, one-cycle pulse on debounced 1→0.
- btn_press, out, N_CH, one-cycle pulse on rise, plus each auto-repeat event.

Behaviour:
- Reset (rst=1 at a clkDis edge): synchroniser flops, levels, stability counters and hold counters all cleared. btn_level, btn_rise, btn_fall and btn_press read 0 in the following cycle. Reset overrides every other input, including mid-count and mid-hold.
- Synchroniser: 2 flops per channel, clocked every clkDis edge and not gated by sample_en. sync = second-stage output.
- Stability counter (width $clog2(STABLE_CNT+1)), updated only on edges where sample_en=1:
  - sync == level → counter cleared to 0.
  - sync != level and counter == STABLE_CNT-1 → level inverts and counter clears.
  - otherwise → counter increments.
  - Result: a glitch shorter than STABLE_CNT ticks never changes the level.
- Edge pulses: btn_rise and btn_fall are registered and assert in exactly the first cycle that btn_level shows its new value, for one cycle only.
- Latency with sample_en=1 every cycle: 2+STABLE_CNT edges from raw transition to level change.
- Hold counter (width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)):
  - Active only when level=1 and repeat_en=1; otherwise held at 0.
  - Increments on each sample_en tick.
  - On reaching REPEAT_DELAY after the rise, or REPEAT_RATE on later repeats: btn_press pulses and the counter reloads to 0 in the same edge.
- btn_press = btn_rise OR repeat event. It is never high for more than one consecutive cycle per event. With repeat_en=0 it equals btn_rise.
- Toggling repeat_en:
  - repeat_en dropping while held clears the hold counter immediately.
  - repeat_en re-asserting while still held restarts from REPEAT_DELAY; no pulse on the re-assertion itself.
- Release: a debounced fall clears the hold counter. No repeat pulse is issued on the fall cycle.
- Channels are fully independent. Simultaneous rise on one channel and fall on another are both reported in the same cycle.
- STABLE_CNT=1: level follows sync on the next sample_en tick with no filtering.

Decomposition:
- Package debounce_pkg:
  - default parameter constants.
  - clog2 helper function used for counter widths.
- Sub-module debounce_chan: one channel (synchroniser, stability counter, edge and repeat logic), instantiated N_CH times via generate.
- debounce_bank: holds only the generate loop and bus wiring.

Test Plan (N_CH=4, STABLE_CNT=3, REPEAT_DELAY=8, REPEAT_RATE=4, sample_en=1 unless stated):
- Reset: hold rst for 3 cycles with all btn_raw=1 → all outputs 0 throughout, and during the cycle after release. After release, btn_level[3:0]=1111 with a single btn_rise=1111 pulse, 5 edges later.
- Clean press: btn_raw[0] rises at edge 0 and is held 20 cycles → btn_level[0]=1 and btn_rise[0]=1 (one cycle) after edge 4. Release at edge 20 → btn_fall[0] pulse after edge 24.
- Glitch: btn_raw[1] high for 2 cycles then low → btn_level[1] stays 0, no rise, fall or press pulses.
- Auto-repeat: repeat_en[2]=1, debounced hold of 18 ticks → btn_press[2] at tick offsets 0, 8, 12, 16 after the rise. Deassert repeat_en[2] at offset 10 in a rerun → pulses only at 0 and 8.
- Gated sampling and reset mid-operation:
  - sample_en pulses every 4th cycle, btn_raw[3] rises → level change occurs on the 3rd tick after sync, 2+9 edges ±3 after the raw edge.
  - Assert rst at tick 2 of the count → no rise pulse; the count restarts after reset.
- Concurrency: channel 0 released and channel 1 pressed at the same edge → btn_fall[0] and btn_rise[1] assert in the same cycle.
